// File: rtl/alu_seq_arb.sv
// alu_seq_arb: two-requester round-robin front end that sequences an external
// ALU through load-A / load-B / execute strobes and returns its result.
// Optional operand cache (skips reloading unchanged A/B) is built when the
// macro ALU_SEQ_OPCACHE_EN is defined; the default build has no cache.
module alu_seq_arb #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic [7:0] cmd0_a,
    input  logic [7:0] cmd1_a,
    input  logic [7:0] cmd0_b,
    input  logic [7:0] cmd1_b,
    input  logic [2:0] cmd0_op,
    input  logic [2:0] cmd1_op,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [8:0] rsp_data,
    output logic       rsp_err,
    output logic       pb1_db,
    output logic       pb2_db,
    output logic       pb3_db,
    output logic [7:0] sw,
    input  logic [8:0] alu_c_plus_carry,
    input  logic [3:0] alu_letters
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        CAPT
    } state_t;

    localparam logic RR_INIT_BIT = (RR_INIT != 0);

    state_t     r_state;
    logic       r_last;
    logic       r_owner;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [2:0] r_op;
    logic       r_pb1;
    logic       r_pb2;
    logic       r_pb3;
    logic [1:0] r_done;
    logic [8:0] r_rsp_data;
    logic       r_rsp_err;

    logic       w_win;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic [2:0] w_op;
    logic       w_hit_a;
    logic       w_hit_b_new;
    logic       w_hit_b_lat;
    logic       w_capt;
    state_t     w_first;

    // Arbitration: a lone request wins; on contention the requester not served last wins.
    always_comb begin
        w_win = 1'b0;
        case (req)
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
    end

    assign w_a  = w_win ? cmd1_a  : cmd0_a;
    assign w_b  = w_win ? cmd1_b  : cmd0_b;
    assign w_op = w_win ? cmd1_op : cmd0_op;

`ifdef ALU_SEQ_OPCACHE_EN
    logic [7:0] r_ca;
    logic [7:0] r_cb;
    logic       r_cav;
    logic       r_cbv;

    assign w_hit_a     = r_cav && (w_a == r_ca);
    assign w_hit_b_new = r_cbv && (w_b == r_cb);
    assign w_hit_b_lat = r_cbv && (r_b == r_cb);

    // Mirror of the operands the ALU holds: updated on the edge each load strobe is seen.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_ca  <= '0;
            r_cb  <= '0;
            r_cav <= 1'b0;
            r_cbv <= 1'b0;
        end else begin
            if (r_pb1) begin
                r_ca  <= r_a;
                r_cav <= 1'b1;
            end
            if (r_pb2) begin
                r_cb  <= r_b;
                r_cbv <= 1'b1;
            end
        end
    end
`else
    assign w_hit_a     = 1'b0;
    assign w_hit_b_new = 1'b0;
    assign w_hit_b_lat = 1'b0;
`endif

    // First sequencing state after a grant: the earliest load that is not already in the ALU.
    always_comb begin
        if (!w_hit_a) begin
            w_first = LOAD_A;
        end else if (!w_hit_b_new) begin
            w_first = LOAD_B;
        end else begin
            w_first = EXEC;
        end
    end

    // Main sequencer: strobe and done flops are set on entry to the state they belong to.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state    <= IDLE;
            r_last     <= ~RR_INIT_BIT;
            r_owner    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_pb1      <= 1'b0;
            r_pb2      <= 1'b0;
            r_pb3      <= 1'b0;
            r_done     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_pb1  <= 1'b0;
            r_pb2  <= 1'b0;
            r_pb3  <= 1'b0;
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (req != 2'b00) begin
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_op    <= w_op;
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_state <= w_first;
                        r_pb1   <= (w_first == LOAD_A);
                        r_pb2   <= (w_first == LOAD_B);
                        r_pb3   <= (w_first == EXEC);
                    end
                end
                LOAD_A: begin
                    if (w_hit_b_lat) begin
                        r_state <= EXEC;
                        r_pb3   <= 1'b1;
                    end else begin
                        r_state <= LOAD_B;
                        r_pb2   <= 1'b1;
                    end
                end
                LOAD_B: begin
                    r_state <= EXEC;
                    r_pb3   <= 1'b1;
                end
                EXEC: begin
                    r_state <= CAPT;
                    r_done  <= {r_owner, ~r_owner};
                end
                CAPT: begin
                    r_rsp_data <= alu_c_plus_carry;
                    r_rsp_err  <= (alu_letters == 4'h0);
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The ALU result only settles in the capture cycle, so it is passed straight
    // through while done is high and held in r_rsp_* afterwards.
    assign w_capt   = (r_done != 2'b00);
    assign rsp_data = w_capt ? alu_c_plus_carry : r_rsp_data;
    assign rsp_err  = w_capt ? (alu_letters == 4'h0) : r_rsp_err;

    assign gnt    = (!rstn && (r_state == IDLE) && (req != 2'b00)) ? {w_win, ~w_win} : 2'b00;
    assign done   = r_done;
    assign pb1_db = r_pb1;
    assign pb2_db = r_pb2;
    assign pb3_db = r_pb3;
    assign sw     = r_pb1 ? r_a :
                    r_pb2 ? r_b :
                    r_pb3 ? {5'b00000, r_op} : 8'h00;

endmodule

// File: tb/tb_alu_seq_arb.sv
// Self-checking bench for alu_seq_arb with a behavioural ALU attached.
// Also covers the cached build when ALU_SEQ_OPCACHE_EN is defined.
module tb_alu_seq_arb;

    localparam int unsigned RR_INIT = 0;
`ifdef ALU_SEQ_OPCACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] req;
    logic [7:0] cmd0_a, cmd1_a, cmd0_b, cmd1_b;
    logic [2:0] cmd0_op, cmd1_op;
    logic [1:0] gnt, done;
    logic [8:0] rsp_data;
    logic       rsp_err;
    logic       pb1_db, pb2_db, pb3_db;
    logic [7:0] sw;
    logic [8:0] alu_c_plus_carry;
    logic [3:0] alu_letters;

    int n_cmp = 0;
    int n_bad = 0;

    // reference-level state: who was served last, what the ALU holds
    bit       m_last;
    bit [7:0] m_ca, m_cb;
    bit       m_cav, m_cbv;

    always #5 clk = ~clk;

    alu_seq_arb #(.RR_INIT(RR_INIT)) dut (
        .clk(clk), .rstn(rstn), .req(req),
        .cmd0_a(cmd0_a), .cmd1_a(cmd1_a), .cmd0_b(cmd0_b), .cmd1_b(cmd1_b),
        .cmd0_op(cmd0_op), .cmd1_op(cmd1_op),
        .gnt(gnt), .done(done), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .pb1_db(pb1_db), .pb2_db(pb2_db), .pb3_db(pb3_db), .sw(sw),
        .alu_c_plus_carry(alu_c_plus_carry), .alu_letters(alu_letters)
    );

    // ALU function: {letters, carry, value}; ops 0 and 7 are "no operation"
    function automatic logic [12:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] r;
        logic [3:0] l;
        l = {1'b0, op};
        case (op)
            3'd1: r = {1'b0, a} + {1'b0, b};
            3'd2: r = {1'b0, a} - {1'b0, b};
            3'd3: r = {1'b0, a & b};
            3'd4: r = {1'b0, a | b};
            3'd5: r = {1'b0, ~a};
            3'd6: r = {1'b0, a ^ b};
            default: begin r = '0; l = 4'h0; end
        endcase
        return {l, r};
    endfunction

    // behavioural ALU: registers loaded by the strobes, result registered on execute
    logic [7:0] alu_ra, alu_rb;
    always_ff @(posedge clk) begin
        if (rstn) begin
            alu_ra <= '0;
            alu_rb <= '0;
            {alu_letters, alu_c_plus_carry} <= '0;
        end else begin
            if (pb1_db) alu_ra <= sw;
            if (pb2_db) alu_rb <= sw;
            if (pb3_db) {alu_letters, alu_c_plus_carry} <= alu_fn(alu_ra, alu_rb, sw[2:0]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_last = (RR_INIT != 0) ? 1'b0 : 1'b1;
        m_cav  = 1'b0;
        m_cbv  = 1'b0;
    endtask

    function automatic bit win_of(input logic [1:0] rq);
        if (rq == 2'b01) return 1'b0;
        if (rq == 2'b10) return 1'b1;
        return ~m_last;
    endfunction

    task automatic do_reset();
        rstn = 1'b1;
        req  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        model_reset();
    endtask

    // One command from request to the cycle after done; entered and left at posedge+1.
    task automatic run_txn(input logic [1:0] rq,
                           input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                           input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1,
                           input logic [8:0] exp_data, input logic exp_err, input string tag);
        bit          w;
        logic [7:0]  ea, eb;
        logic [2:0]  eop;
        bit          skip_a, skip_b;
        logic [10:0] stg[$];
        int          k;
        cmd0_a = a0; cmd0_b = b0; cmd0_op = op0;
        cmd1_a = a1; cmd1_b = b1; cmd1_op = op1;
        req = rq;
        w = win_of(rq);
        #1;
        k = 0;
        while (gnt == 2'b00 && k < 20) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk({tag, "_gnt"}, gnt, w ? 2'b10 : 2'b01);
        if (gnt == 2'b00) begin
            req = 2'b00;
            return;
        end
        m_last = w;
        ea  = w ? a1 : a0;
        eb  = w ? b1 : b0;
        eop = w ? op1 : op0;
        skip_a = CACHE && m_cav && (ea == m_ca);
        skip_b = CACHE && m_cbv && (eb == m_cb);
        @(posedge clk);
        #1;
        req = 2'b00;
        cmd0_a = 8'($urandom); cmd0_b = 8'($urandom); cmd0_op = 3'($urandom);
        cmd1_a = 8'($urandom); cmd1_b = 8'($urandom); cmd1_op = 3'($urandom);
        if (!skip_a) stg.push_back({3'b001, ea});
        if (!skip_b) stg.push_back({3'b010, eb});
        stg.push_back({3'b100, 5'b00000, eop});
        foreach (stg[i]) begin
            chk({tag, "_strobe"}, {done, pb3_db, pb2_db, pb1_db, sw}, {2'b00, stg[i]});
            @(posedge clk);
            #1;
        end
        chk({tag, "_done"}, done, w ? 2'b10 : 2'b01);
        chk({tag, "_rsp"}, {rsp_err, rsp_data}, {exp_err, exp_data});
        chk({tag, "_capt_quiet"}, {pb3_db, pb2_db, pb1_db, sw}, 0);
        if (!skip_a) begin m_ca = ea; m_cav = 1'b1; end
        if (!skip_b) begin m_cb = eb; m_cbv = 1'b1; end
        @(posedge clk);
        #1;
        chk({tag, "_hold"}, {done, rsp_err, rsp_data}, {2'b00, exp_err, exp_data});
    endtask

    typedef struct {
        logic [1:0] rq;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [8:0] data;
        logic       err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] gval[$];
        int         gcyc[$];
        int         cyc;
        bit         seen;
        int         k;

        tbl[0] = '{2'b01, 8'h0F, 8'h01, 3'd1, 9'h010, 1'b0};
        tbl[1] = '{2'b01, 8'h00, 8'h01, 3'd2, 9'h1FF, 1'b0};
        tbl[2] = '{2'b10, 8'hFF, 8'h01, 3'd1, 9'h100, 1'b0};
        tbl[3] = '{2'b10, 8'h05, 8'h03, 3'd6, 9'h006, 1'b0};
        tbl[4] = '{2'b01, 8'hAA, 8'h55, 3'd7, 9'h000, 1'b1};
        tbl[5] = '{2'b10, 8'h3C, 8'hC3, 3'd0, 9'h000, 1'b1};
        tbl[6] = '{2'b01, 8'hF0, 8'h3C, 3'd3, 9'h030, 1'b0};
        tbl[7] = '{2'b10, 8'hF0, 8'h0F, 3'd4, 9'h0FF, 1'b0};
        tbl[8] = '{2'b01, 8'h80, 8'h80, 3'd1, 9'h100, 1'b0};
        tbl[9] = '{2'b10, 8'h10, 8'h20, 3'd2, 9'h1F0, 1'b0};

        // reset with a live request: nothing may be granted or strobed
        rstn = 1'b1;
        req  = 2'b01;
        cmd0_a = 8'h12; cmd0_b = 8'h34; cmd0_op = 3'd1;
        cmd1_a = 8'h56; cmd1_b = 8'h78; cmd1_op = 3'd2;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {gnt, done, pb3_db, pb2_db, pb1_db, sw, rsp_err, rsp_data}, 0);
        rstn = 1'b0;
        req  = 2'b00;
        model_reset();
        #1;
        chk("post_reset_idle", {gnt, done, pb3_db, pb2_db, pb1_db, sw, rsp_err, rsp_data}, 0);
        @(posedge clk);
        #1;

        // directed vectors
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rq == 2'b01)
                run_txn(2'b01, tbl[i].a, tbl[i].b, tbl[i].op,
                        8'($urandom), 8'($urandom), 3'($urandom),
                        tbl[i].data, tbl[i].err, $sformatf("vec%0d", i));
            else
                run_txn(2'b10, 8'($urandom), 8'($urandom), 3'($urandom),
                        tbl[i].a, tbl[i].b, tbl[i].op,
                        tbl[i].data, tbl[i].err, $sformatf("vec%0d", i));
        end

        // continuous contention: alternating grants, five cycles apart
        do_reset();
        cmd0_a = 8'h11; cmd0_b = 8'h22; cmd0_op = 3'd1;
        cmd1_a = 8'h33; cmd1_b = 8'h44; cmd1_op = 3'd2;
        req = 2'b11;
        #1;
        cyc = 0;
        while (gval.size() < 4 && cyc < 40) begin
            if (gnt != 2'b00) begin
                gval.push_back(gnt);
                gcyc.push_back(cyc);
            end
            @(posedge clk);
            #2;
            cyc++;
        end
        req = 2'b00;
        chk("rr_count", gval.size(), 4);
        for (int i = 0; i < gval.size(); i++) begin
            chk($sformatf("rr_order%0d", i), gval[i],
                ((i % 2 == 0) == (RR_INIT == 0)) ? 2'b01 : 2'b10);
            if (i > 0) chk($sformatf("rr_gap%0d", i), gcyc[i] - gcyc[i-1], 5);
        end
        repeat (6) @(posedge clk);
        #1;
        do_reset();

        // reset while the execute strobe is out: command is abandoned
        cmd0_a = 8'h0F; cmd0_b = 8'h01; cmd0_op = 3'd1;
        req = 2'b01;
        #1;
        k = 0;
        while (gnt == 2'b00 && k < 20) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("abort_gnt", gnt, 2'b01);
        @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pb3", {pb3_db, pb2_db, pb1_db}, 3'b100);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("abort_quiet", {gnt, done, pb3_db, pb2_db, pb1_db, sw}, 0);
        rstn = 1'b0;
        model_reset();
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done != 2'b00 || pb1_db || pb2_db || pb3_db) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        run_txn(2'b01, 8'h0F, 8'h01, 3'd1, 8'h00, 8'h00, 3'd0, 9'h010, 1'b0, "fresh");

`ifdef ALU_SEQ_OPCACHE_EN
        // repeated operands: second command goes straight to execute
        do_reset();
        run_txn(2'b01, 8'h05, 8'h03, 3'd1, 8'h00, 8'h00, 3'd0, 9'h008, 1'b0, "cache1");
        run_txn(2'b01, 8'h05, 8'h03, 3'd6, 8'h00, 8'h00, 3'd0, 9'h006, 1'b0, "cache2");
`endif

        // randomized traffic against the reference model
        for (int t = 0; t < 60; t++) begin
            logic [1:0]  rq;
            logic [7:0]  a0, b0, a1, b1;
            logic [2:0]  op0, op1;
            logic [12:0] ref_v;
            bit          w;
            rq = 2'($urandom_range(0, 3));
            if (rq == 2'b00) begin
                req = 2'b00;
                #1;
                chk("rand_idle", {gnt, done}, 0);
                @(posedge clk);
                #1;
            end else begin
                a0 = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                b0 = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                a1 = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                b1 = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                op0 = 3'($urandom);
                op1 = 3'($urandom);
                w = win_of(rq);
                ref_v = w ? alu_fn(a1, b1, op1) : alu_fn(a0, b0, op0);
                run_txn(rq, a0, b0, op0, a1, b1, op1, ref_v[8:0],
                        w ? (op1 == 3'd0 || op1 == 3'd7) : (op0 == 3'd0 || op0 == 3'd7),
                        $sformatf("rand%0d", t));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
